// File: rtl/class_code_monitor.sv
// rtl/class_code_monitor.sv - class code FIFO with illegal-code halt and per-class occurrence counters
module class_code_monitor #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [4:0]       in_code,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_code,
    output logic [2:0]       out_idx,
    input  logic             clr_err,
    output logic             err,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = 1;
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] OCC_ONE  = 1;

    typedef enum logic {RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [4:0]       code_q [DEPTH];
    logic [4:0]       code_d [DEPTH];
    logic [2:0]       idx_q [DEPTH];
    logic [2:0]       idx_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q [6];
    logic [CNT_W-1:0] cnt_d [6];

    logic       full, empty, push, pop, illegal;
    logic [2:0] in_idx, cls;

    always_comb begin
        in_idx = 3'd7;
        case (in_code)
            5'd19: in_idx = 3'd0;
            5'd20: in_idx = 3'd1;
            5'd21: in_idx = 3'd2;
            5'd22: in_idx = 3'd3;
            5'd23: in_idx = 3'd4;
            default: in_idx = 3'd7;
        endcase
    end

    assign illegal   = (in_idx == 3'd7);
    assign cls       = illegal ? 3'd5 : in_idx;
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign in_ready  = (state_q == RUN) && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign err       = err_q;
    // Head is masked while empty so stale storage never reaches the outputs.
    assign out_code  = empty ? 5'd0 : code_q[rd_ptr_q];
    assign out_idx   = empty ? 3'd0 : idx_q[rd_ptr_q];

    always_comb begin
        cnt_out = '0;
        if (cnt_sel <= 3'd5) cnt_out = cnt_q[cnt_sel];
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        code_d   = code_q;
        idx_d    = idx_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        cnt_d    = cnt_q;

        // An illegal push outranks a coincident clr_err.
        if (push && illegal) begin
            state_d = HALT;
            err_d   = 1'b1;
        end else if (clr_err) begin
            err_d   = 1'b0;
            state_d = RUN;
        end

        if (push) begin
            code_d[wr_ptr_q] = in_code;
            idx_d[wr_ptr_q]  = in_idx;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
            if (cnt_q[cls] != '1) cnt_d[cls] = cnt_q[cls] + OCC_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            err_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                code_q[i] <= '0;
                idx_q[i]  <= '0;
            end
            for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_class_code_monitor.sv
// tb/tb_class_code_monitor.sv - scoreboard bench for class_code_monitor
module tb_class_code_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_code = 5'd0;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] cnt_sel = 3'd0;
    logic       in_ready, out_valid, err;
    logic [4:0] out_code;
    logic [2:0] out_idx;
    logic [7:0] cnt_out;

    typedef struct packed {
        logic [4:0] code;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    int   checks = 0;
    int   failures = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   base;

    class_code_monitor #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_idx(out_idx),
        .clr_err(clr_err), .err(err),
        .cnt_sel(cnt_sel), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [2:0] ref_idx(input logic [4:0] c);
        case (c)
            5'd19:   return 3'd0;
            5'd20:   return 3'd1;
            5'd21:   return 3'd2;
            5'd22:   return 3'd3;
            5'd23:   return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sample handshakes on the falling edge, compare pops against the expected queue.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_e = exp_q.pop_front();
                    check_eq("pop_code", 32'(out_code), 32'(exp_e.code));
                    check_eq("pop_idx", 32'(out_idx), 32'(exp_e.idx));
                end
                n_pop++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_code, ref_idx(in_code)});
                n_push++;
            end
        end
    end

    initial begin
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_code", 32'(out_code), 0);
        check_eq("rst_out_idx", 32'(out_idx), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_cnt", 32'(cnt_out), 0);
        step();
        step();
        rst_n = 1'b1;
        check_eq("rel_in_ready", 32'(in_ready), 1);

        // Fill to DEPTH with legal codes, then full-with-pop and push+pop.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_code = 5'(19 + i);
            step();
        end
        check_eq("full_in_ready", 32'(in_ready), 0);
        check_eq("full_pushes", 32'(n_push), 4);
        check_eq("full_head", 32'(out_code), 19);
        in_code = 5'd23;
        step();
        check_eq("full_no_push", 32'(n_push), 4);
        out_ready = 1'b1;
        step();
        check_eq("full_pop_only", 32'(n_push), 4);
        check_eq("full_pop_cnt", 32'(n_pop), 1);
        check_eq("after_pop_ready", 32'(in_ready), 1);
        step();
        check_eq("pushpop_push", 32'(n_push), 5);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("pushpop_not_full", 32'(in_ready), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_valid; k++) step();
        out_ready = 1'b0;
        check_eq("drain_empty", 32'(out_valid), 0);
        check_eq("drain_pops", 32'(n_pop), 5);

        // Illegal code halts intake but keeps the FIFO draining.
        in_valid = 1'b1;
        in_code  = 5'd7;
        step();
        in_valid = 1'b0;
        check_eq("ill_err", 32'(err), 1);
        check_eq("ill_in_ready", 32'(in_ready), 0);
        check_eq("ill_head_code", 32'(out_code), 7);
        check_eq("ill_head_idx", 32'(out_idx), 7);
        cnt_sel = 3'd5;
        #1;
        check_eq("ill_cnt", 32'(cnt_out), 1);
        cnt_sel = 3'd2;
        #1;
        check_eq("cnt21_one", 32'(cnt_out), 1);
        in_valid = 1'b1;
        in_code  = 5'd19;
        step();
        in_valid = 1'b0;
        check_eq("halt_no_push", 32'(n_push), 6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("halt_drained", 32'(out_valid), 0);
        check_eq("halt_err_held", 32'(err), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check_eq("clr_err", 32'(err), 0);
        check_eq("clr_in_ready", 32'(in_ready), 1);

        // Illegal push coincident with clr_err: push wins.
        in_valid = 1'b1;
        in_code  = 5'd0;
        clr_err  = 1'b1;
        step();
        in_valid = 1'b0;
        clr_err  = 1'b0;
        check_eq("coinc_err", 32'(err), 1);
        check_eq("coinc_halt", 32'(in_ready), 0);
        cnt_sel = 3'd5;
        #1;
        check_eq("coinc_cnt", 32'(cnt_out), 2);
        clr_err = 1'b1;
        step();
        clr_err   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("coinc_cleared", 32'(err), 0);
        check_eq("coinc_drained", 32'(out_valid), 0);

        // Asynchronous reset with entries queued.
        in_valid = 1'b1;
        in_code  = 5'd19; step();
        in_code  = 5'd20; step();
        in_code  = 5'd22; step();
        in_valid = 1'b0;
        check_eq("q3_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_valid", 32'(out_valid), 0);
        check_eq("async_code", 32'(out_code), 0);
        for (int s = 0; s < 6; s++) begin
            cnt_sel = 3'(s);
            #1;
            check_eq($sformatf("async_cnt_%0d", s), 32'(cnt_out), 0);
        end
        step();
        step();
        rst_n = 1'b1;
        check_eq("rerel_ready", 32'(in_ready), 1);
        check_eq("rerel_valid", 32'(out_valid), 0);

        // Counter saturation: 300 pushes of code 21.
        base      = n_push;
        in_valid  = 1'b1;
        in_code   = 5'd21;
        out_ready = 1'b1;
        for (int k = 0; k < 400 && (n_push - base) < 300; k++) step();
        in_valid = 1'b0;
        check_eq("sat_pushes", 32'(n_push - base), 300);
        for (int k = 0; k < 20 && out_valid; k++) step();
        out_ready = 1'b0;
        check_eq("sat_drained", 32'(out_valid), 0);
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s);
            #1;
            check_eq($sformatf("sat_cnt_%0d", s), 32'(cnt_out), (s == 2) ? 255 : 0);
        end
        check_eq("sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/class_code_monitor.md
CLASS_CODE_MONITOR -- requirements
Module: class_code_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entry count (power of 2, minimum 2).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of each occurrence counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream class code is valid.
REQ-006 SHALL have port in_code, input, 5, meaning the class code from the upstream classifier.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts in_code this cycle.
REQ-008 SHALL have port out_valid, output, 1, meaning the FIFO head is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream consumes the head.
REQ-010 SHALL have port out_code, output, 5, meaning the FIFO head code.
REQ-011 SHALL have port out_idx, output, 3, meaning the FIFO head class index.
REQ-012 SHALL have port clr_err, input, 1, a single-cycle pulse that clears the error condition.
REQ-013 SHALL have port err, output, 1, the sticky illegal-code flag.
REQ-014 SHALL have port cnt_sel, input, 3, which selects the counter to read.
REQ-015 SHALL have port cnt_out, output, CNT_W, the value of the selected counter.

Function
REQ-016 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready.
REQ-017 SHALL map a code to its class index: 19->0, 20->1, 21->2, 22->3, 23->4; any other code is illegal -> 7.
REQ-018 SHALL compute the index at push time and store it alongside the code; out_code/out_idx SHALL be driven from the stored entry with no combinational path from in_code.
REQ-019 SHALL use FSM states RUN and HALT.
REQ-020 SHALL drive in_ready = (state==RUN) && !full.
REQ-021 SHALL drive out_valid = !empty, independent of state; FIFO SHALL keep draining in HALT.
REQ-022 SHALL transition RUN->HALT on the edge where an illegal code is pushed; that code SHALL still be stored and delivered with out_idx=7.
REQ-023 SHALL transition HALT->RUN on the edge after clr_err=1; clr_err in RUN SHALL be ignored apart from REQ-025.
REQ-024 SHALL set err on the same edge as RUN->HALT and hold it until clr_err.
REQ-025 SHALL clear err on clr_err; if an illegal push and clr_err coincide in RUN, the push SHALL win (err=1, HALT).
REQ-026 SHALL keep an occupancy count in 0..DEPTH; push only: +1; pop only: -1; push+pop together: unchanged, with the head advancing and the new entry written.
REQ-027 SHALL allow pop when full (in_ready=0 that cycle) and SHALL ignore pop when empty.
REQ-028 SHALL use read/write pointers that wrap modulo DEPTH; data order SHALL be strict FIFO.
REQ-029 SHALL keep six CNT_W counters, five per legal class (indices 0..4) and one for illegal codes (index 5), each incremented by 1 on a push of its class.
REQ-030 SHALL saturate each counter at 2^CNT_W-1 with no wrap.
REQ-031 SHALL make cnt_out combinational from cnt_sel: values 0..5 select a counter; 6 and 7 return 0.
REQ-032 SHALL clear counters only by reset; clr_err SHALL NOT affect them.
REQ-033 SHALL have a push-to-out_valid latency of 1 cycle when the FIFO is empty.

Reset
REQ-034 SHALL, while rst_n=0 (asynchronously): state=RUN, FIFO empty, pointers 0, err=0, counters 0, out_valid=0, out_code=0, out_idx=0.
REQ-035 SHALL assert in_ready=1 in the first cycle after reset release.
REQ-036 SHALL, if reset occurs mid-operation, discard all FIFO contents with no partial pop or push completing.

Verification
REQ-037 SHALL verify: push 19,20,21,22,23 with out_ready=0 and DEPTH=4 -> four accepted, in_ready=0 after the 4th; pops return idx 0,1,2,3 in order; then 23 is accepted.
REQ-038 SHALL verify: push 5'd7 -> err=1 and in_ready=0 on the next cycle; head code 7 with idx 7; cnt_sel=5 gives 1; pulse clr_err -> err=0, in_ready=1 on the following cycle.
REQ-039 SHALL verify: FIFO full with in_valid=1 and out_ready=1 -> pop occurs, no push that cycle; next cycle push+pop keeps count at DEPTH-1.
REQ-040 SHALL verify: CNT_W=8, 300 pushes of code 21 -> cnt_sel=2 reads 255; other counters read 0; cnt_sel=6 reads 0.
REQ-041 SHALL verify: illegal push coincident with clr_err -> err=1 and HALT.
REQ-042 SHALL verify: assert rst_n=0 with 3 entries queued -> out_valid=0 immediately (asynchronous); all counters read 0.
